// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_arb_pkg
// Brief   : Shared types and helpers for the SRAM port arbiter.
// Rev     : 1.0
// ============================================================================
package sram_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int FIXED_PRIO_MASTER = 0;

  // Successor of idx in the round-robin ring 1..num_masters-1.
  function automatic int rr_next(input int idx, input int num_masters);
    return (idx + 1 >= num_masters) ? 1 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : sram_port_arbiter_if
// Brief     : Master request/return bus plus SRAM macro pins of the arbiter.
// Rev       : 1.0
// ============================================================================
interface sram_port_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8
);

  logic [NUM_MASTERS-1:0]            REQ;
  logic [NUM_MASTERS-1:0]            WE;
  logic [NUM_MASTERS-1:0]            LOCK;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] ADDR;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] WDATA;
  logic [NUM_MASTERS-1:0]            GNT;
  logic [NUM_MASTERS-1:0]            RVALID;
  logic [DATA_WIDTH-1:0]             RDATA;
  logic                              CEN;
  logic                              WEN;
  logic [ADDR_WIDTH-1:0]             A_SRAM;
  logic [DATA_WIDTH-1:0]             D_SRAM;
  logic [DATA_WIDTH-1:0]             Q_SRAM;
  logic                              BUSY;

  modport slave (
    input  REQ, WE, LOCK, ADDR, WDATA, Q_SRAM,
    output GNT, RVALID, RDATA, CEN, WEN, A_SRAM, D_SRAM, BUSY
  );

  modport master (
    output REQ, WE, LOCK, ADDR, WDATA, Q_SRAM,
    input  GNT, RVALID, RDATA, CEN, WEN, A_SRAM, D_SRAM, BUSY
  );

endinterface
`default_nettype wire

// File: rtl/sram_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : sram_arb_rr_pick
// Brief  : First requesting master among 1..N-1, searching upward from rr_ptr.
// Rev    : 1.0
// ============================================================================
module sram_arb_rr_pick #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = 2
) (
  input  wire [NUM_MASTERS-1:0] i_req,
  input  wire [IDX_W-1:0]       i_rr_ptr,
  output logic                  o_found,
  output logic [IDX_W-1:0]      o_idx
);

  int               w_cand;
  logic [IDX_W-1:0] w_cand_idx;

  // Scan from the far end so the candidate closest to rr_ptr is written last.
  always_comb begin
    o_found    = 1'b0;
    o_idx      = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = NUM_MASTERS - 2; k >= 0; k--) begin
      w_cand     = ((int'(i_rr_ptr) - 1 + k) % (NUM_MASTERS - 1)) + 1;
      w_cand_idx = IDX_W'(w_cand);
      if (i_req[w_cand_idx]) begin
        o_found = 1'b1;
        o_idx   = w_cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sram_port_arbiter
// Brief  : N-master SRAM arbiter: fixed-priority master 0, round-robin rest,
//          burst locking, registered SRAM command and tagged read return.
// Rev    : 1.0
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_MASTERS  = 3,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input wire                CLK,
  input wire                RST,
  sram_port_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_e                         r_state, w_state_next;
  logic [IDX_W-1:0]                   r_owner, w_owner_next;
  logic [IDX_W-1:0]                   r_rr_ptr, w_rr_next;
  logic [IDX_W-1:0]                   w_sel, w_pick_idx;
  logic                               w_pick_found, w_xfer;
  logic [NUM_MASTERS-1:0]             w_gnt, w_rvalid;
  logic [ADDR_WIDTH-1:0]              w_addr_sel;
  logic [DATA_WIDTH-1:0]              w_wdata_sel;
  logic                               w_we_sel;

  logic                               r_cen, r_wen;
  logic [ADDR_WIDTH-1:0]              r_a;
  logic [DATA_WIDTH-1:0]              r_d;
  logic                               r_cmd_rd;
  logic [IDX_W-1:0]                   r_cmd_tag;
  logic [READ_LATENCY-1:0]            r_rd_pipe;
  logic [READ_LATENCY-1:0][IDX_W-1:0] r_tag_pipe;

  sram_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .i_req    (bus.REQ),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_pick_found),
    .o_idx    (w_pick_idx)
  );

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_rr_next    = r_rr_ptr;
    w_xfer       = 1'b0;
    w_sel        = '0;
    if (!RST) begin
      case (r_state)
        ARB: begin
          if (bus.REQ[FIXED_PRIO_MASTER]) begin
            w_xfer = 1'b1;
            w_sel  = IDX_W'(FIXED_PRIO_MASTER);
          end else if (w_pick_found) begin
            w_xfer    = 1'b1;
            w_sel     = w_pick_idx;
            w_rr_next = IDX_W'(rr_next(int'(w_pick_idx), NUM_MASTERS));
          end
          if (w_xfer && bus.LOCK[w_sel]) begin
            w_state_next = LOCKED;
            w_owner_next = w_sel;
          end
        end
        LOCKED: begin
          // The cycle that drops LOCK still carries the owner's last transfer.
          w_sel  = r_owner;
          w_xfer = bus.REQ[r_owner];
          if (!bus.LOCK[r_owner]) w_state_next = ARB;
        end
        default: w_state_next = ARB;
      endcase
    end
  end

  always_comb begin
    w_gnt       = '0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    w_we_sel    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_gnt[i]    = w_xfer;
        w_addr_sel  = bus.ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata_sel = bus.WDATA[i*DATA_WIDTH +: DATA_WIDTH];
        w_we_sel    = bus.WE[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ARB;
      r_owner  <= '0;
      r_rr_ptr <= IDX_W'(1);
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cen     <= 1'b1;
      r_wen     <= 1'b1;
      r_a       <= '0;
      r_d       <= '0;
      r_cmd_rd  <= 1'b0;
      r_cmd_tag <= '0;
    end else begin
      r_cmd_rd  <= w_xfer & ~w_we_sel;
      r_cmd_tag <= w_sel;
      if (w_xfer) begin
        r_cen <= 1'b0;
        r_wen <= ~w_we_sel;
        r_a   <= w_addr_sel;
        r_d   <= w_wdata_sel;
      end else begin
        r_cen <= 1'b1;
        r_wen <= 1'b1;
      end
    end
  end

  // Tag travels alongside the SRAM access so it emerges with Q_SRAM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_pipe  <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_rd_pipe[0]  <= r_cmd_rd;
      r_tag_pipe[0] <= r_cmd_tag;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_rd_pipe[k]  <= r_rd_pipe[k-1];
        r_tag_pipe[k] <= r_tag_pipe[k-1];
      end
    end
  end

  always_comb begin
    w_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_rvalid[i] = r_rd_pipe[READ_LATENCY-1] &&
                    (r_tag_pipe[READ_LATENCY-1] == IDX_W'(i));
    end
  end

  assign bus.GNT    = w_gnt;
  assign bus.RVALID = w_rvalid;
  assign bus.RDATA  = bus.Q_SRAM;
  assign bus.CEN    = r_cen;
  assign bus.WEN    = r_wen;
  assign bus.A_SRAM = r_a;
  assign bus.D_SRAM = r_d;
  assign bus.BUSY   = (r_state == LOCKED) || r_cmd_rd || (|r_rd_pipe);

endmodule
`default_nettype wire
